// File: rtl/alu_pipe_if.sv
// alu_pipe_if
// Groups the operation bus and the result bus of alu_pipe, including the
// valid/ready handshake on both sides.
//
// Ports (signals):
//   valid_i / ready_o  : input-side handshake (upstream -> ALU)
//   opcode_i           : [4:2] arithmetic op, [1:0] shift op
//   shamt_i            : shift distance
//   input_a / input_b  : operands
//   valid_o / ready_i  : output-side handshake (ALU -> downstream)
//   alu_out            : final shifted result
//   carry_o / ovf_o    : stage-1 carry/borrow and signed overflow (pre-shift)
//   zero_o / neg_o     : flags of the final result
//
// Modports:
//   master : the side that issues operations and consumes results (testbench,
//            operand-fetch / writeback logic)
//   slave  : the ALU itself
interface alu_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               valid_i;
    logic               ready_o;
    logic [4:0]         opcode_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic [WIDTH-1:0]   input_a;
    logic [WIDTH-1:0]   input_b;
    logic               valid_o;
    logic               ready_i;
    logic [WIDTH-1:0]   alu_out;
    logic               carry_o;
    logic               ovf_o;
    logic               zero_o;
    logic               neg_o;

    modport master (
        output valid_i, opcode_i, shamt_i, input_a, input_b, ready_i,
        input  ready_o, valid_o, alu_out, carry_o, ovf_o, zero_o, neg_o
    );

    modport slave (
        input  valid_i, opcode_i, shamt_i, input_a, input_b, ready_i,
        output ready_o, valid_o, alu_out, carry_o, ovf_o, zero_o, neg_o
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe
// Two-stage pipelined ALU. Stage 1 performs the arithmetic/logic operation and
// produces carry/borrow and signed-overflow flags; stage 2 applies a
// variable-distance shift and produces the zero/negative flags from the final
// value. Both sides use a valid/ready handshake, giving one result per cycle
// with full backpressure support (up to two operations held while stalled).
//
// Ports:
//   clock_i : single clock, rising edge
//   reset_i : synchronous, active-high reset
//   bus     : alu_pipe_if slave modport (operation in, result out)
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic        clock_i,
    input  logic        reset_i,
    alu_pipe_if.slave   bus
);

    typedef enum logic [2:0] {
        OP_PASS_A = 3'd0,
        OP_ADD    = 3'd1,
        OP_SUB    = 3'd2,
        OP_AND    = 3'd3,
        OP_OR     = 3'd4,
        OP_INC    = 3'd5,
        OP_DEC    = 3'd6,
        OP_ZERO   = 3'd7
    } arith_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'd0,
        SH_LSL  = 2'd1,
        SH_LSR  = 2'd2,
        SH_ZERO = 2'd3
    } shift_op_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic               s1_valid_q,  s1_valid_d;
    logic [WIDTH-1:0]   s1_result_q, s1_result_d;
    logic               s1_carry_q,  s1_carry_d;
    logic               s1_ovf_q,    s1_ovf_d;
    shift_op_e          s1_shop_q,   s1_shop_d;
    logic [SHAMT_W-1:0] s1_shamt_q,  s1_shamt_d;

    logic               valid_q,     valid_d;
    logic [WIDTH-1:0]   out_q,       out_d;
    logic               carry_q,     carry_d;
    logic               ovf_q,       ovf_d;
    logic               zero_q,      zero_d;
    logic               neg_q,       neg_d;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic adv1;
    logic adv2;

    // Stage 2 may advance when it is empty or its result is being taken;
    // stage 1 may advance when it is empty or stage 2 is advancing. This
    // lets a full pipe drain and fill in the same cycle.
    always_comb begin
        adv2 = ~valid_q | bus.ready_i;
        adv1 = ~s1_valid_q | adv2;
    end

    assign bus.ready_o = adv1;

    // ------------------------------------------------------------------
    // Stage 1: arithmetic / logic
    // ------------------------------------------------------------------
    arith_op_e        arith_op;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] arith_result;
    logic             arith_carry;
    logic             arith_ovf;

    assign arith_op = arith_op_e'(bus.opcode_i[4:2]);

    // INC and DEC share the adder/subtractor with a constant 1 as the second
    // operand. Both paths are computed one bit wider so that the top bit is
    // the carry-out (add) or the borrow (sub, 1 when A < subtrahend).
    always_comb begin
        addend   = ((arith_op == OP_INC) || (arith_op == OP_DEC)) ? ONE : bus.input_b;
        sum_ext  = {1'b0, bus.input_a} + {1'b0, addend};
        diff_ext = {1'b0, bus.input_a} - {1'b0, addend};
        add_ovf  = (bus.input_a[WIDTH-1] == addend[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != bus.input_a[WIDTH-1]);
        sub_ovf  = (bus.input_a[WIDTH-1] != addend[WIDTH-1]) &&
                   (diff_ext[WIDTH-1] != bus.input_a[WIDTH-1]);
    end

    // Select the stage-1 result and flags. Logic ops and PASS/ZERO never
    // report carry or overflow.
    always_comb begin
        arith_result = '0;
        arith_carry  = 1'b0;
        arith_ovf    = 1'b0;
        case (arith_op)
            OP_PASS_A: arith_result = bus.input_a;
            OP_ADD, OP_INC: begin
                arith_result = sum_ext[WIDTH-1:0];
                arith_carry  = sum_ext[WIDTH];
                arith_ovf    = add_ovf;
            end
            OP_SUB, OP_DEC: begin
                arith_result = diff_ext[WIDTH-1:0];
                arith_carry  = diff_ext[WIDTH];
                arith_ovf    = sub_ovf;
            end
            OP_AND:  arith_result = bus.input_a & bus.input_b;
            OP_OR:   arith_result = bus.input_a | bus.input_b;
            OP_ZERO: arith_result = '0;
            default: arith_result = '0;
        endcase
    end

    // Stage-1 register next state. The valid bit follows valid_i whenever the
    // stage advances (a bubble is simply valid=0); the data fields only load
    // on a real transfer so idle input values never disturb them.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_result_d = s1_result_q;
        s1_carry_d  = s1_carry_q;
        s1_ovf_d    = s1_ovf_q;
        s1_shop_d   = s1_shop_q;
        s1_shamt_d  = s1_shamt_q;
        if (adv1) begin
            s1_valid_d = bus.valid_i;
            if (bus.valid_i) begin
                s1_result_d = arith_result;
                s1_carry_d  = arith_carry;
                s1_ovf_d    = arith_ovf;
                s1_shop_d   = shift_op_e'(bus.opcode_i[1:0]);
                s1_shamt_d  = bus.shamt_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: shifter and final flags
    // ------------------------------------------------------------------
    logic             shamt_too_big;
    logic [WIDTH-1:0] shifted;

    // Distances at or beyond the datapath width shift everything out.
    always_comb begin
        shamt_too_big = (32'(s1_shamt_q) >= 32'(WIDTH));
        shifted       = '0;
        case (s1_shop_q)
            SH_NONE: shifted = s1_result_q;
            SH_LSL:  shifted = shamt_too_big ? '0 : (s1_result_q << s1_shamt_q);
            SH_LSR:  shifted = shamt_too_big ? '0 : (s1_result_q >> s1_shamt_q);
            SH_ZERO: shifted = '0;
            default: shifted = '0;
        endcase
    end

    // Output register next state. While stalled everything holds, so the
    // presented result and its flags stay stable until accepted.
    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        if (adv2) begin
            valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d   = shifted;
                carry_d = s1_carry_q;
                ovf_d   = s1_ovf_q;
                zero_d  = (shifted == '0);
                neg_d   = shifted[WIDTH-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers (synchronous reset discards anything in flight)
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            s1_valid_q  <= 1'b0;
            s1_result_q <= '0;
            s1_carry_q  <= 1'b0;
            s1_ovf_q    <= 1'b0;
            s1_shop_q   <= SH_NONE;
            s1_shamt_q  <= '0;
            valid_q     <= 1'b0;
            out_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
            neg_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_result_q <= s1_result_d;
            s1_carry_q  <= s1_carry_d;
            s1_ovf_q    <= s1_ovf_d;
            s1_shop_q   <= s1_shop_d;
            s1_shamt_q  <= s1_shamt_d;
            valid_q     <= valid_d;
            out_q       <= out_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.alu_out = out_q;
    assign bus.carry_o = carry_q;
    assign bus.ovf_o   = ovf_q;
    assign bus.zero_o  = zero_q;
    assign bus.neg_o   = neg_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe
// Self-checking bench for alu_pipe. A 32-bit/5-bit-shamt instance carries the
// vector table and the handshake sequences; a second instance with a 6-bit
// shift field covers distances at and beyond the datapath width.
module tb_alu_pipe;

    localparam logic [2:0] A_PASS = 3'd0, A_ADD = 3'd1, A_SUB = 3'd2, A_AND = 3'd3;
    localparam logic [2:0] A_OR   = 3'd4, A_INC = 3'd5, A_DEC = 3'd6, A_ZERO = 3'd7;
    localparam logic [1:0] S_NONE = 2'd0, S_LSL = 2'd1, S_LSR = 2'd2, S_ZERO = 2'd3;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  shamt;
        logic [31:0] exp_out;
        logic        exp_c;
        logic        exp_v;
        logic        exp_z;
        logic        exp_n;
    } vec_t;

    logic clock;
    logic reset;

    int tests_run;
    int tests_failed;
    int out_count;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];

    alu_pipe_if #(.WIDTH(32), .SHAMT_W(5)) bus ();
    alu_pipe_if #(.WIDTH(32), .SHAMT_W(6)) bus6 ();

    alu_pipe #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus)
    );

    alu_pipe #(.WIDTH(32), .SHAMT_W(6)) dut6 (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard time limit so a stuck run still terminates with a visible failure
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic [2:0] ar, input logic [1:0] sh,
                          input logic [31:0] a, input logic [31:0] b, input logic [5:0] shamt,
                          input logic [31:0] e, input logic c, input logic v,
                          input logic z, input logic n);
        vec_t t;
        t.op = {ar, sh}; t.a = a; t.b = b; t.shamt = shamt;
        t.exp_out = e; t.exp_c = c; t.exp_v = v; t.exp_z = z; t.exp_n = n;
        vecs.push_back(t);
    endtask

    // One isolated op on the main instance with ready_i=1: checks the exact
    // two-cycle latency and every output field.
    task automatic applyStimulus(input vec_t t, input int idx);
        bus.valid_i  = 1'b1;
        bus.opcode_i = t.op;
        bus.input_a  = t.a;
        bus.input_b  = t.b;
        bus.shamt_i  = t.shamt[4:0];
        bus.ready_i  = 1'b1;
        @(posedge clock); #1;
        bus.valid_i = 1'b0;
        checkOutput($sformatf("vec%0d_latency_early", idx), 32'(bus.valid_o), 32'd0);
        @(posedge clock); #1;
        checkOutput($sformatf("vec%0d_valid", idx), 32'(bus.valid_o), 32'd1);
        checkOutput($sformatf("vec%0d_out",   idx), bus.alu_out,        t.exp_out);
        checkOutput($sformatf("vec%0d_carry", idx), 32'(bus.carry_o),   32'(t.exp_c));
        checkOutput($sformatf("vec%0d_ovf",   idx), 32'(bus.ovf_o),     32'(t.exp_v));
        checkOutput($sformatf("vec%0d_zero",  idx), 32'(bus.zero_o),    32'(t.exp_z));
        checkOutput($sformatf("vec%0d_neg",   idx), 32'(bus.neg_o),     32'(t.exp_n));
    endtask

    // Same idea on the wide-shamt instance, result only.
    task automatic applyWide(input logic [1:0] sh, input logic [5:0] shamt,
                             input logic [31:0] a, input logic [31:0] e, input int idx);
        bus6.valid_i  = 1'b1;
        bus6.opcode_i = {A_PASS, sh};
        bus6.input_a  = a;
        bus6.input_b  = 32'h0;
        bus6.shamt_i  = shamt;
        bus6.ready_i  = 1'b1;
        @(posedge clock); #1;
        bus6.valid_i = 1'b0;
        @(posedge clock); #1;
        checkOutput($sformatf("wide%0d_valid", idx), 32'(bus6.valid_o), 32'd1);
        checkOutput($sformatf("wide%0d_out",   idx), bus6.alu_out,        e);
    endtask

    // One clock of INC-stream traffic with a scoreboard: every accepted input
    // queues A+1, every output handshake must match the queue head.
    task automatic streamCycle(input logic v, input logic [31:0] a, input logic rdy,
                               output logic accepted);
        bus.valid_i  = v;
        bus.opcode_i = {A_INC, S_NONE};
        bus.input_a  = a;
        bus.input_b  = 32'h0;
        bus.shamt_i  = 5'd0;
        bus.ready_i  = rdy;
        #1;
        accepted = bus.valid_i && bus.ready_o;
        if (bus.valid_o && bus.ready_i) begin
            out_count++;
            if (exp_q.size() == 0)
                checkOutput("stream_spurious", 32'(bus.valid_o), 32'd0);
            else
                checkOutput("stream_order", bus.alu_out, exp_q.pop_front());
        end
        if (accepted) exp_q.push_back(a + 32'd1);
        @(posedge clock); #1;
    endtask

    initial begin
        logic acc;
        int   next_a;
        int   guard;
        int   base;

        tests_run = 0; tests_failed = 0; out_count = 0;
        bus.valid_i = 1'b0; bus.opcode_i = '0; bus.shamt_i = '0;
        bus.input_a = '0;   bus.input_b = '0;  bus.ready_i = 1'b1;
        bus6.valid_i = 1'b0; bus6.opcode_i = '0; bus6.shamt_i = '0;
        bus6.input_a = '0;   bus6.input_b = '0;  bus6.ready_i = 1'b1;

        //             op      shift   A             B             sh  out           c  v  z  n
        addVec(A_ADD,  S_NONE, 32'hFFFFFFFF, 32'h00000001, 0,  32'h00000000, 1, 0, 1, 0);
        addVec(A_ADD,  S_LSL,  32'h7FFFFFFF, 32'h00000001, 1,  32'h00000000, 0, 1, 1, 0);
        addVec(A_SUB,  S_NONE, 32'h00000003, 32'h00000005, 0,  32'hFFFFFFFE, 1, 0, 0, 1);
        addVec(A_PASS, S_LSR,  32'h80000000, 32'h0000DEAD, 31, 32'h00000001, 0, 0, 0, 0);
        addVec(A_PASS, S_ZERO, 32'h12345678, 32'h00000000, 0,  32'h00000000, 0, 0, 1, 0);
        addVec(A_AND,  S_NONE, 32'hF0F0F0F0, 32'hFFF00FF0, 0,  32'hF0F000F0, 0, 0, 0, 1);
        addVec(A_OR,   S_NONE, 32'h00F000F0, 32'h0F000F00, 0,  32'h0FF00FF0, 0, 0, 0, 0);
        addVec(A_INC,  S_NONE, 32'hFFFFFFFF, 32'h12345678, 0,  32'h00000000, 1, 0, 1, 0);
        addVec(A_INC,  S_NONE, 32'h7FFFFFFF, 32'h00000000, 0,  32'h80000000, 0, 1, 0, 1);
        addVec(A_DEC,  S_NONE, 32'h00000000, 32'h00000000, 0,  32'hFFFFFFFF, 1, 0, 0, 1);
        addVec(A_DEC,  S_NONE, 32'h80000000, 32'h00000000, 0,  32'h7FFFFFFF, 0, 1, 0, 0);
        addVec(A_ZERO, S_NONE, 32'h00000005, 32'h00000007, 0,  32'h00000000, 0, 0, 1, 0);
        addVec(A_SUB,  S_NONE, 32'h80000000, 32'h00000001, 0,  32'h7FFFFFFF, 0, 1, 0, 0);
        addVec(A_ADD,  S_LSL,  32'h00000001, 32'h00000002, 4,  32'h00000030, 0, 0, 0, 0);
        addVec(A_PASS, S_LSL,  32'h00000001, 32'hFFFFFFFF, 31, 32'h80000000, 0, 0, 0, 1);
        addVec(A_SUB,  S_NONE, 32'h00000005, 32'h00000005, 0,  32'h00000000, 0, 0, 1, 0);
        addVec(A_ADD,  S_NONE, 32'h80000000, 32'h80000000, 0,  32'h00000000, 1, 1, 1, 0);
        addVec(A_PASS, S_LSR,  32'h000000AB, 32'h00000000, 0,  32'h000000AB, 0, 0, 0, 0);
        addVec(A_INC,  S_LSR,  32'h0000000F, 32'h00000000, 2,  32'h00000004, 0, 0, 0, 0);

        // Reset and check the post-reset state
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("reset_valid", 32'(bus.valid_o), 32'd0);
        checkOutput("reset_out",   bus.alu_out,      32'd0);
        checkOutput("reset_carry", 32'(bus.carry_o), 32'd0);
        checkOutput("reset_ovf",   32'(bus.ovf_o),   32'd0);
        checkOutput("reset_zero",  32'(bus.zero_o),  32'd1);
        checkOutput("reset_neg",   32'(bus.neg_o),   32'd0);
        checkOutput("reset_ready", 32'(bus.ready_o), 32'd1);

        // Vector table on the main instance
        foreach (vecs[i]) applyStimulus(vecs[i], i);
        @(posedge clock); #1;
        checkOutput("table_drained", 32'(bus.valid_o), 32'd0);

        // Shift distances at and beyond the width on the 6-bit shamt instance
        applyWide(S_LSR, 6'd40, 32'h80000000, 32'h00000000, 0);
        applyWide(S_LSR, 6'd31, 32'h80000000, 32'h00000001, 1);
        applyWide(S_LSL, 6'd32, 32'h00000001, 32'h00000000, 2);
        applyWide(S_LSR, 6'd32, 32'hFFFFFFFF, 32'h00000000, 3);
        applyWide(S_LSL, 6'd63, 32'hFFFFFFFF, 32'h00000000, 4);
        applyWide(S_LSR, 6'd1,  32'h80000000, 32'h40000000, 5);

        // Backpressure: two ops fill the pipe, then ready_o drops and the
        // presented result holds while downstream stalls.
        exp_q.delete();
        base = out_count;
        streamCycle(1'b1, 32'd10, 1'b0, acc);
        checkOutput("bp_accept1", 32'(acc), 32'd1);
        checkOutput("bp_ready_after1", 32'(bus.ready_o), 32'd1);
        streamCycle(1'b1, 32'd11, 1'b0, acc);
        checkOutput("bp_accept2", 32'(acc), 32'd1);
        checkOutput("bp_ready_after2", 32'(bus.ready_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            streamCycle(1'b1, 32'd12, 1'b0, acc);
            checkOutput("bp_stall_accept", 32'(acc),           32'd0);
            checkOutput("bp_stall_valid",  32'(bus.valid_o),   32'd1);
            checkOutput("bp_stall_out",    bus.alu_out,        32'd11);
            checkOutput("bp_stall_zero",   32'(bus.zero_o),    32'd0);
        end
        next_a = 12;
        guard  = 0;
        while ((next_a <= 13 || exp_q.size() > 0) && guard < 20) begin
            streamCycle(next_a <= 13, 32'(next_a), 1'b1, acc);
            if (acc) next_a++;
            guard++;
        end
        checkOutput("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("bp_out_count",   32'(out_count - base), 32'd4);

        // Simultaneous drain and fill on a full pipe for 5 cycles
        base = out_count;
        streamCycle(1'b1, 32'd20, 1'b0, acc);
        streamCycle(1'b1, 32'd21, 1'b0, acc);
        checkOutput("sim_full_ready", 32'(bus.ready_o), 32'd0);
        next_a = 22;
        for (int k = 0; k < 5; k++) begin
            streamCycle(1'b1, 32'(next_a), 1'b1, acc);
            checkOutput("sim_accept", 32'(acc), 32'd1);
            if (acc) next_a++;
        end
        checkOutput("sim_out_count",   32'(out_count - base), 32'd5);
        checkOutput("sim_ready_still", 32'(bus.ready_o),      32'd1);
        checkOutput("sim_still_full",  32'(bus.valid_o),      32'd1);
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            streamCycle(1'b0, 32'd0, 1'b1, acc);
            guard++;
        end
        checkOutput("sim_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("sim_total_out",   32'(out_count - base), 32'd7);

        // Reset with two ops in flight: they must vanish
        streamCycle(1'b1, 32'd40, 1'b0, acc);
        streamCycle(1'b1, 32'd41, 1'b0, acc);
        bus.valid_i = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        checkOutput("rst_mid_valid", 32'(bus.valid_o), 32'd0);
        checkOutput("rst_mid_out",   bus.alu_out,      32'd0);
        checkOutput("rst_mid_zero",  32'(bus.zero_o),  32'd1);
        checkOutput("rst_mid_ready", 32'(bus.ready_o), 32'd1);
        base = out_count;
        for (int k = 0; k < 4; k++) streamCycle(1'b0, 32'd0, 1'b1, acc);
        checkOutput("rst_mid_no_ghost", 32'(out_count - base), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
